// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit words from a qualified bit stream.
// Define PARITY_CHECK_EN to expect one even-parity bit after each word.
module serial_word_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             parity_err
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_PARITY  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_WORD = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;

    logic             order_eff;
    logic [WIDTH-1:0] shifted;

    // Bit order is taken live on the first bit of a word, then frozen for the rest of it.
    assign order_eff = (cnt_q == '0) ? msb_first : order_q;
    assign shifted   = order_eff ? {shift_q[WIDTH-2:0], sin} : {sin, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        if (clear) begin
            state_d = S_COLLECT;
            shift_d = '0;
            cnt_d   = '0;
        end else if (sin_valid) begin
            case (state_q)
                S_COLLECT: begin
                    shift_d = shifted;
                    order_d = order_eff;
                    if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d = S_PARITY;
                        cnt_d   = FULL_WORD;
`else
                        dout_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
`ifdef PARITY_CHECK_EN
                    // Even parity: data bits plus parity bit must XOR to zero.
                    dout_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = (^shift_q) ^ sin;
`endif
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_COLLECT;
            shift_q <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign bit_count  = cnt_q;
    assign busy       = (cnt_q != '0);
    assign parity_err = perr_q;

endmodule
